// File: rtl/io_capture.sv
// io_capture: input-side sampler for the five bus pins (logic-analyzer / sniffer mode).
// Pins are double-flop synchronized, a masked pattern trigger starts the capture, and
// samples taken at a programmable rate are queued in a FIFO that the MCU drains.
// Optional feature macro: IO_CAPTURE_TIMESTAMP_EN -- when defined, each stored sample
// carries an 11-bit tick count since the trigger in rd_data[15:5]; when undefined the
// upper rd_data bits read as zero and no timestamp is stored.
module io_capture #(
  parameter int NPINS = 5,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPINS-1:0]       pin_in,
  input  logic                   arm,
  input  logic                   abort,
  input  logic [15:0]            div,
  input  logic [15:0]            len,
  input  logic [NPINS-1:0]       trig_mask,
  input  logic [NPINS-1:0]       trig_val,
  input  logic                   rd_en,
  output logic [15:0]            rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

`ifdef IO_CAPTURE_TIMESTAMP_EN
  localparam int TSW = 11;
  localparam int EW  = NPINS + TSW;
`else
  localparam int EW  = NPINS;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;

  logic [NPINS-1:0] sync1_r;
  logic [NPINS-1:0] samp_r;
  logic [15:0]      div_cnt_r;
  logic [15:0]      cnt_r;
  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic [AW:0]      wptr_nxt_s;
  logic [AW:0]      rptr_nxt_s;
  logic [AW:0]      level_nxt_s;
  logic [EW-1:0]    mem_r [DEPTH];
  logic [EW-1:0]    wr_entry_s;

  logic [AW:0]      level_r;
  logic             empty_r;
  logic             overflow_r;
  logic             busy_r;
  logic             done_r;
  logic             rd_valid_r;
  logic [15:0]      rd_data_r;
  logic             busy_nxt_s;
  logic             done_nxt_s;

  logic             active_s;
  logic             tick_s;
  logic             abort_s;
  logic             arm_s;
  logic             trig_hit_s;
  logic             wr_req_s;
  logic             full_s;
  logic             pop_s;
  logic             wr_ok_s;
  logic             drop_s;
  logic [15:0]      cnt_inc_s;
  logic             last_s;

`ifdef IO_CAPTURE_TIMESTAMP_EN
  logic [TSW-1:0]   ts_r;
  logic [TSW-1:0]   ts_wr_s;
`endif

  // Control decode: tick, trigger match, accepted arm/abort, FIFO push/pop decisions.
  always_comb begin
    active_s   = (state_r == ST_ARMED) || (state_r == ST_CAPTURE);
    tick_s     = active_s && (div_cnt_r == div);
    // abort has no effect in IDLE; elsewhere it overrides everything else this cycle
    abort_s    = abort && (state_r != ST_IDLE);
    // arm is only honoured from IDLE/DONE, and a simultaneous abort suppresses it
    arm_s      = arm && !abort && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    trig_hit_s = (((samp_r ^ trig_val) & trig_mask) == {NPINS{1'b0}});
    if (state_r == ST_ARMED) begin
      wr_req_s = tick_s && trig_hit_s && !abort_s;
    end else if (state_r == ST_CAPTURE) begin
      wr_req_s = tick_s && !abort_s;
    end else begin
      wr_req_s = 1'b0;
    end
    full_s    = (level_r == DEPTH_V);
    pop_s     = rd_en && !empty_r;
    // a pop in the same cycle frees the slot the new sample goes into
    wr_ok_s   = wr_req_s && (!full_s || pop_s);
    drop_s    = wr_req_s && full_s && !pop_s;
    cnt_inc_s = cnt_r + 16'd1;
    if (state_r == ST_ARMED) begin
      last_s = (len == 16'd1);
    end else begin
      last_s = (len != 16'd0) && (cnt_inc_s == len);
    end
  end

`ifdef IO_CAPTURE_TIMESTAMP_EN
  // Timestamp of the sample being written: zero for the trigger sample, +1 per tick after.
  always_comb begin
    if (state_r == ST_CAPTURE) begin
      ts_wr_s = ts_r + 11'd1;
    end else begin
      ts_wr_s = 11'd0;
    end
    wr_entry_s = {ts_wr_s, samp_r};
  end

  // Timestamp register advances with every capture tick and restarts at the trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_r <= 11'd0;
    end else if (wr_req_s) begin
      ts_r <= ts_wr_s;
    end
  end
`else
  // Without timestamps a FIFO entry is just the synchronized pin vector.
  always_comb begin
    wr_entry_s = samp_r;
  end
`endif

  // Two-stage synchronizer for the asynchronous pin inputs; samp_r is the usable sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= {NPINS{1'b0}};
      samp_r  <= {NPINS{1'b0}};
    end else begin
      sync1_r <= pin_in;
      samp_r  <= sync1_r;
    end
  end

  // Sample-rate divider: counts 0..div while searching/capturing, wraps on each tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= 16'd0;
    end else if (arm_s) begin
      div_cnt_r <= 16'd0;
    end else if (active_s) begin
      if (tick_s) begin
        div_cnt_r <= 16'd0;
      end else begin
        div_cnt_r <= div_cnt_r + 16'd1;
      end
    end else begin
      div_cnt_r <= 16'd0;
    end
  end

  // Number of samples taken since the trigger, including the trigger sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 16'd0;
    end else if (arm_s) begin
      cnt_r <= 16'd0;
    end else if (wr_req_s && (state_r == ST_ARMED)) begin
      cnt_r <= 16'd1;
    end else if (wr_req_s) begin
      cnt_r <= cnt_inc_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (arm_s) begin
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED, ST_CAPTURE: begin
        if (abort_s) begin
          state_nxt_s = ST_IDLE;
        end else if (wr_req_s) begin
          if (drop_s || last_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_CAPTURE;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DONE: begin
        if (abort_s) begin
          state_nxt_s = ST_IDLE;
        end else if (arm_s) begin
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM output decode, taken from the next state so the registered flags track the state.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_ARMED:   busy_nxt_s = 1'b1;
      ST_CAPTURE: busy_nxt_s = 1'b1;
      ST_DONE:    done_nxt_s = 1'b1;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Next FIFO pointers and occupancy; arm empties the FIFO.
  always_comb begin
    if (arm_s) begin
      wptr_nxt_s = {(AW+1){1'b0}};
      rptr_nxt_s = {(AW+1){1'b0}};
    end else begin
      if (wr_ok_s) begin
        wptr_nxt_s = wptr_r + PTR_ONE;
      end else begin
        wptr_nxt_s = wptr_r;
      end
      if (pop_s) begin
        rptr_nxt_s = rptr_r + PTR_ONE;
      end else begin
        rptr_nxt_s = rptr_r;
      end
    end
    level_nxt_s = wptr_nxt_s - rptr_nxt_s;
  end

  // FIFO pointers, occupancy and empty flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r  <= {(AW+1){1'b0}};
      rptr_r  <= {(AW+1){1'b0}};
      level_r <= {(AW+1){1'b0}};
      empty_r <= 1'b1;
    end else begin
      wptr_r  <= wptr_nxt_s;
      rptr_r  <= rptr_nxt_s;
      level_r <= level_nxt_s;
      empty_r <= (level_nxt_s == {(AW+1){1'b0}});
    end
  end

  // FIFO storage; on a full push+pop the write lands in the slot being read out.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok_s) begin
      mem_r[wptr_r[AW-1:0]] <= wr_entry_s;
    end
  end

  // Read port: registered data with a one-cycle valid strobe; data holds between pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r  <= 16'd0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= pop_s;
      if (pop_s) begin
        rd_data_r <= 16'(mem_r[rptr_r[AW-1:0]]);
      end
    end
  end

  // Sticky overflow flag and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      if (arm_s) begin
        overflow_r <= 1'b0;
      end else if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign empty    = empty_r;
  assign level    = level_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign overflow = overflow_r;

endmodule
